// File: rtl/weight_read_ctrl_if.sv
// Handshake and bus bundle between the weight read controller, the scratch-pad
// loader/RAM and the MAC array.
interface weight_read_ctrl_if #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDRESSWIDTH_W_PAD = 8,
  parameter int ADDRESSWIDTH_F_PAD = 8
);
  logic                          compute_start;
  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num;
  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num;
  logic                          pad_data_ready;
  logic                          weight_load_done;
  logic [DATA_WIDTH-1:0]         weight_rd_data;
  logic                          mac_ready;
  logic [ADDRESSWIDTH_W_PAD-1:0] raddra_filter;
  logic [ADDRESSWIDTH_W_PAD-1:0] base_address;
  logic                          weight_valid;
  logic [DATA_WIDTH-1:0]         weight_data;
  logic                          weight_last;
  logic                          job_last;
  logic                          busy;
  logic                          compute_done;

  // Output handshake: a word transfers in any cycle where weight_valid && mac_ready;
  // while weight_valid is high, weight_data/weight_last/job_last stay stable until taken.
  modport slave (
    input  compute_start, weight_num, pixel_num, pad_data_ready, weight_load_done,
    input  weight_rd_data, mac_ready,
    output raddra_filter, base_address, weight_valid, weight_data, weight_last,
    output job_last, busy, compute_done
  );

  modport master (
    output compute_start, weight_num, pixel_num, pad_data_ready, weight_load_done,
    output weight_rd_data, mac_ready,
    input  raddra_filter, base_address, weight_valid, weight_data, weight_last,
    input  job_last, busy, compute_done
  );
endinterface

// File: rtl/weight_read_ctrl.sv
// Streams weight_num x pixel_num scratch-pad reads into a 2-entry skid buffer
// feeding the MAC, tagging the last word of each pass and of the whole job.
module weight_read_ctrl #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDRESSWIDTH_W_PAD = 8,
  parameter int ADDRESSWIDTH_F_PAD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  weight_read_ctrl_if.slave        bus,
  output logic [1:0]               dbg_state
);
  localparam int W = ADDRESSWIDTH_W_PAD;
  localparam int F = ADDRESSWIDTH_F_PAD;
  localparam int D = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   wn_q, wn_d, w_cnt_q, w_cnt_d, addr_q, addr_d;
  logic [F-1:0]   pn_q, pn_d, p_cnt_q, p_cnt_d;
  logic           inflight_q, inflight_d;
  logic           infl_wlast_q, infl_wlast_d, infl_jlast_q, infl_jlast_d;
  logic [D-1:0]   skid_data_q [2];
  logic [D-1:0]   skid_data_d [2];
  logic [1:0]     skid_wlast_q, skid_wlast_d, skid_jlast_q, skid_jlast_d;
  logic           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]     count_q, count_d;

  logic           pop, w_last, p_last, gate, credit, issue;
  logic [2:0]     occ;

  always_comb begin
    state_d      = state_q;
    wn_d         = wn_q;
    pn_d         = pn_q;
    w_cnt_d      = w_cnt_q;
    p_cnt_d      = p_cnt_q;
    addr_d       = addr_q;
    skid_data_d  = skid_data_q;
    skid_wlast_d = skid_wlast_q;
    skid_jlast_d = skid_jlast_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

    pop    = (count_q != 2'd0) && bus.mac_ready;
    w_last = (w_cnt_q == wn_q - W'(1));
    p_last = (p_cnt_q == pn_q - F'(1));
    gate   = (p_cnt_q != '0) || bus.pad_data_ready || bus.weight_load_done;
    // Occupancy after this cycle's departure and the arriving read; a new read
    // lands one cycle later, so at most one slot may be committed here.
    occ    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    credit = (occ < 3'd2);
    issue  = (state_q == RUN) && credit && gate;

    inflight_d   = issue;
    infl_wlast_d = w_last;
    infl_jlast_d = w_last && p_last;

    case (state_q)
      IDLE: begin
        if (bus.compute_start) begin
          wn_d    = bus.weight_num;
          pn_d    = bus.pixel_num;
          w_cnt_d = '0;
          p_cnt_d = '0;
          state_d = (bus.weight_num == '0 || bus.pixel_num == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = w_cnt_q;
          if (w_last) begin
            w_cnt_d = '0;
            p_cnt_d = p_cnt_q + F'(1);
            if (p_last) state_d = DRAIN;
          end else begin
            w_cnt_d = w_cnt_q + W'(1);
          end
        end
      end
      DRAIN: begin
        if (count_q == 2'd0 && !inflight_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    // RAM data for last cycle's read arrives now.
    if (inflight_q) begin
      skid_data_d[wr_ptr_q]  = bus.weight_rd_data;
      skid_wlast_d[wr_ptr_q] = infl_wlast_q;
      skid_jlast_d[wr_ptr_q] = infl_jlast_q;
      wr_ptr_d               = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wn_q         <= '0;
      pn_q         <= '0;
      w_cnt_q      <= '0;
      p_cnt_q      <= '0;
      addr_q       <= '0;
      inflight_q   <= 1'b0;
      infl_wlast_q <= 1'b0;
      infl_jlast_q <= 1'b0;
      skid_data_q  <= '{default: '0};
      skid_wlast_q <= '0;
      skid_jlast_q <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      wn_q         <= wn_d;
      pn_q         <= pn_d;
      w_cnt_q      <= w_cnt_d;
      p_cnt_q      <= p_cnt_d;
      addr_q       <= addr_d;
      inflight_q   <= inflight_d;
      infl_wlast_q <= infl_wlast_d;
      infl_jlast_q <= infl_jlast_d;
      skid_data_q  <= skid_data_d;
      skid_wlast_q <= skid_wlast_d;
      skid_jlast_q <= skid_jlast_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  assign bus.raddra_filter = issue ? w_cnt_q : addr_q;
  assign bus.base_address  = bus.raddra_filter;
  assign bus.weight_valid  = (count_q != 2'd0);
  assign bus.weight_data   = bus.weight_valid ? skid_data_q[rd_ptr_q] : '0;
  assign bus.weight_last   = bus.weight_valid && skid_wlast_q[rd_ptr_q];
  assign bus.job_last      = bus.weight_valid && skid_jlast_q[rd_ptr_q];
  assign bus.busy          = (state_q != IDLE);
  assign bus.compute_done  = (state_q == DONE);
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_weight_read_ctrl.sv
// Directed bench for weight_read_ctrl: registered RAM model, in-order
// scoreboard on accepted words, and cycle checks on addresses and pulses.
module tb_weight_read_ctrl;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  weight_read_ctrl_if #(.DATA_WIDTH(16), .ADDRESSWIDTH_W_PAD(8), .ADDRESSWIDTH_F_PAD(8)) bus ();

  weight_read_ctrl #(.DATA_WIDTH(16), .ADDRESSWIDTH_W_PAD(8), .ADDRESSWIDTH_F_PAD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [15:0] ram_word(input logic [7:0] a);
    return 16'h5A00 + {8'h00, a} * 16'd3;
  endfunction

  always @(posedge clk) bus.weight_rd_data <= ram_word(bus.raddra_filter);

  // Scoreboard state
  logic [17:0] exp_q[$];
  int acc_cyc[$];
  int n_checks = 0;
  int n_pass   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int valid_seen = 0;
  int base_acc, base_done, base_valid, base_idx, start_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
  endtask

  task automatic monitor();
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.compute_done) done_cnt++;
        if (bus.weight_valid) valid_seen++;
        if (bus.weight_valid && bus.mac_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("word", {14'b0, bus.weight_data, bus.weight_last, bus.job_last}, {14'b0, e});
          end
          acc_cyc.push_back(cycle);
          acc_cnt++;
        end
      end
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int wn, input int pn);
    for (int p = 0; p < pn; p++)
      for (int w = 0; w < wn; w++)
        exp_q.push_back({ram_word(8'(w)), w == wn - 1, (w == wn - 1) && (p == pn - 1)});
    base_acc   = acc_cnt;
    base_done  = done_cnt;
    base_valid = valid_seen;
    base_idx   = acc_cyc.size();
    step();
    bus.weight_num    = 8'(wn);
    bus.pixel_num     = 8'(pn);
    bus.compute_start = 1'b1;
    start_cyc         = cycle;
    step();
    bus.compute_start = 1'b0;
  endtask

  task automatic finish_job(input int nwords, input bit toggle);
    int n;
    n = 0;
    while (n < 600) begin
      @(negedge clk);
      if (bus.compute_done) break;
      step();
      if (toggle) bus.mac_ready = ~bus.mac_ready;
      n++;
    end
    if (n >= 600) check("done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
    check("word_count", 32'(acc_cnt - base_acc), 32'(nwords));
    check("exp_left", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt - base_done), 32'd1);
    step();
    bus.mac_ready = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_raddr"}, 32'(bus.raddra_filter), 32'd0);
    check({tag, "_base"}, 32'(bus.base_address), 32'd0);
    check({tag, "_valid_data_tags"},
          {13'b0, bus.weight_valid, bus.weight_data, bus.weight_last, bus.job_last}, 32'd0);
    check({tag, "_busy_done"}, {30'b0, bus.busy, bus.compute_done}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none
    rst = 1'b1;
    bus.compute_start = 1'b0;
    bus.weight_num = '0;
    bus.pixel_num = '0;
    bus.pad_data_ready = 1'b0;
    bus.weight_load_done = 1'b0;
    bus.mac_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check_outputs_zero("reset");
    step();
    rst = 1'b0;

    // Pass 0 stalls until the loader reports progress.
    start_job(3, 2);
    repeat (5) @(negedge clk);
    check("stall_raddr", 32'(bus.raddra_filter), 32'd0);
    check("stall_valid_busy", {30'b0, bus.weight_valid, bus.busy}, 32'd1);
    step();
    bus.weight_load_done = 1'b1;
    @(negedge clk);
    check("resume_addr0", 32'(bus.raddra_filter), 32'd0);
    @(negedge clk);
    check("resume_addr1", 32'(bus.raddra_filter), 32'd1);
    check("resume_valid_lat1", 32'(bus.weight_valid), 32'd0);
    @(negedge clk);
    check("resume_valid_lat2", 32'(bus.weight_valid), 32'd1);
    finish_job(6, 1'b0);
    step();
    bus.weight_load_done = 1'b0;
    bus.pad_data_ready   = 1'b1;

    // Back-to-back streaming: 4 x 2 words on consecutive cycles.
    start_job(4, 2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stream_raddr", 32'(bus.raddra_filter), 32'(i % 4));
    end
    finish_job(8, 1'b0);
    check("stream_latency", 32'(acc_cyc[base_idx] - start_cyc), 32'd3);
    check("stream_back_to_back", 32'(acc_cyc[base_idx + 7] - acc_cyc[base_idx]), 32'd7);

    // Backpressure: mac_ready toggling every cycle.
    start_job(5, 2);
    finish_job(10, 1'b1);

    // Empty jobs go straight to DONE.
    start_job(0, 3);
    @(negedge clk);
    check("zero_wn_busy_done", {30'b0, bus.busy, bus.compute_done}, 32'd3);
    @(negedge clk);
    check("zero_wn_idle", {30'b0, bus.busy, bus.compute_done}, 32'd0);
    repeat (3) @(negedge clk);
    check("zero_wn_no_valid", 32'(valid_seen - base_valid), 32'd0);
    check("zero_wn_done_cnt", 32'(done_cnt - base_done), 32'd1);
    start_job(4, 0);
    @(negedge clk);
    check("zero_pn_busy_done", {30'b0, bus.busy, bus.compute_done}, 32'd3);
    repeat (4) @(negedge clk);
    check("zero_pn_no_valid", 32'(valid_seen - base_valid), 32'd0);
    check("zero_pn_done_cnt", 32'(done_cnt - base_done), 32'd1);

    // Abort during pass 1, then a clean restart.
    start_job(5, 3);
    n = 0;
    while ((acc_cnt - base_acc) < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_pass1", 32'(n < 200), 32'd1);
    step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check_outputs_zero("abort");
    step();
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base_done), 32'd0);
    start_job(5, 3);
    finish_job(15, 1'b0);

    // compute_start during RUN must not restart or resize the job.
    start_job(2, 2);
    step();
    bus.weight_num    = 8'd7;
    bus.pixel_num     = 8'd7;
    bus.compute_start = 1'b1;
    step();
    bus.compute_start = 1'b0;
    finish_job(4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected end of test", cycle);
    $fatal(1, "timeout");
  end
endmodule
